// File: rtl/apmu_ibex_wb_stage.sv
// ---------------------------------------------------------------------------
// apmu_ibex_wb_stage
//   Writeback stage behind the execute block. It holds at most one
//   instruction. An ALU/mult-div result retires one cycle after capture. A
//   load waits in WB_LOAD until the LSU response arrives and then writes the
//   returned data. The stage also produces a retire pulse, a retired-
//   instruction counter, a load bus-error pulse, and a sticky flag that
//   records LSU responses that arrived when no load was waiting.
//
//   Ports
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     en_wb_i, flush_i       ID retire enable and controller flush
//     ex_valid_i ..pc_id_i   EX instruction: result, load flag, rd, we, pc
//     lsu_resp_*_i           LSU response valid, data and bus error
//     ready_wb_o             WB can accept an instruction this cycle
//     rf_*_wb_o              register-file write port and forwarding valid
//     instr_done_wb_o        one-cycle retire pulse
//     pc_wb_o                PC of the instruction in WB
//     load_err_o             load completed with a bus error
//     spurious_resp_o        sticky: LSU response seen outside WB_LOAD
//     retired_cnt_o          retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module apmu_ibex_wb_stage #(
    parameter int unsigned CntWidth = 32,
    parameter bit          ResetAll = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_wb_i,
    input  logic                flush_i,
    input  logic                ex_valid_i,
    input  logic [31:0]         result_ex_i,
    input  logic                instr_is_load_i,
    input  logic                rf_we_id_i,
    input  logic [4:0]          rf_waddr_id_i,
    input  logic [31:0]         pc_id_i,
    input  logic                lsu_resp_valid_i,
    input  logic [31:0]         lsu_rdata_i,
    input  logic                lsu_resp_err_i,
    output logic                ready_wb_o,
    output logic                rf_we_wb_o,
    output logic [4:0]          rf_waddr_wb_o,
    output logic [31:0]         rf_wdata_wb_o,
    output logic                rf_wdata_fwd_valid_o,
    output logic                instr_done_wb_o,
    output logic [31:0]         pc_wb_o,
    output logic                load_err_o,
    output logic                spurious_resp_o,
    output logic [CntWidth-1:0] retired_cnt_o
);

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2
    } wb_state_e;

    wb_state_e           state_q, state_d;
    logic                we_q;
    logic [4:0]          rd_q;
    logic [31:0]         pc_q;
    logic [31:0]         result_q;
    logic                spurious_q;
    logic [CntWidth-1:0] cnt_q;
    logic                accept;
    logic                in_load;

    assign in_load = (state_q == WB_LOAD);

    // A pending load frees the stage in its own response cycle, so a new
    // instruction can be captured while the old one retires.
    assign ready_wb_o = ~in_load | lsu_resp_valid_i;
    assign accept     = en_wb_i & ex_valid_i & ready_wb_o & ~flush_i;

    always_comb begin
        state_d              = WB_IDLE;
        rf_we_wb_o           = 1'b0;
        rf_wdata_wb_o        = 32'h0;
        rf_wdata_fwd_valid_o = 1'b0;
        instr_done_wb_o      = 1'b0;
        load_err_o           = 1'b0;

        if (accept) begin
            state_d = instr_is_load_i ? WB_LOAD : WB_ALU;
        end else if (in_load && !lsu_resp_valid_i) begin
            // Flush does not reach an entry already in WB; wait for the data.
            state_d = WB_LOAD;
        end

        unique case (state_q)
            WB_ALU: begin
                rf_we_wb_o           = we_q;
                rf_wdata_wb_o        = result_q;
                rf_wdata_fwd_valid_o = we_q;
                instr_done_wb_o      = 1'b1;
            end
            WB_LOAD: begin
                rf_wdata_wb_o = lsu_rdata_i;
                if (lsu_resp_valid_i) begin
                    rf_we_wb_o           = we_q & ~lsu_resp_err_i;
                    rf_wdata_fwd_valid_o = we_q & ~lsu_resp_err_i;
                    instr_done_wb_o      = 1'b1;
                    load_err_o           = lsu_resp_err_i;
                end
            end
            default: ;
        endcase
    end

    assign rf_waddr_wb_o   = (state_q != WB_IDLE) ? rd_q : 5'd0;
    assign pc_wb_o         = (state_q != WB_IDLE) ? pc_q : 32'h0;
    assign spurious_resp_o = spurious_q;
    assign retired_cnt_o   = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= WB_IDLE;
            we_q       <= 1'b0;
            spurious_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Writes to x0 are dropped here so downstream never sees them.
                we_q <= rf_we_id_i & (rf_waddr_id_i != 5'd0);
            end
            if (lsu_resp_valid_i && !in_load) begin
                spurious_q <= 1'b1;
            end
            if (instr_done_wb_o) begin
                cnt_q <= cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
            end
        end
    end

    // Payload registers: outputs are gated by state, so their reset is optional.
    generate
        if (ResetAll) begin : g_data_rst
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rd_q     <= 5'd0;
                    pc_q     <= 32'h0;
                    result_q <= 32'h0;
                end else if (accept) begin
                    rd_q     <= rf_waddr_id_i;
                    pc_q     <= pc_id_i;
                    result_q <= result_ex_i;
                end
            end
        end else begin : g_data_nrst
            always_ff @(posedge clk_i) begin
                if (accept) begin
                    rd_q     <= rf_waddr_id_i;
                    pc_q     <= pc_id_i;
                    result_q <= result_ex_i;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_apmu_ibex_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_apmu_ibex_wb_stage
//   Two instances share all inputs: the default configuration and a 4-bit
//   counter / ResetAll=1 variant. A slot-based reference model predicts
//   every output on each cycle. Directed scenarios come first, followed by
//   random traffic.
// ---------------------------------------------------------------------------
module tb_apmu_ibex_wb_stage;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_ni;
    logic        en_wb_i, flush_i, ex_valid_i, instr_is_load_i, rf_we_id_i;
    logic [31:0] result_ex_i, pc_id_i, lsu_rdata_i;
    logic [4:0]  rf_waddr_id_i;
    logic        lsu_resp_valid_i, lsu_resp_err_i;

    logic        ready_wb_o, rf_we_wb_o, rf_wdata_fwd_valid_o, instr_done_wb_o;
    logic        load_err_o, spurious_resp_o;
    logic [4:0]  rf_waddr_wb_o;
    logic [31:0] rf_wdata_wb_o, pc_wb_o, retired_cnt_o;

    logic        d4_ready, d4_we, d4_fwd, d4_done, d4_lerr, d4_spur;
    logic [4:0]  d4_waddr;
    logic [31:0] d4_wdata, d4_pc;
    logic [3:0]  d4_cnt;

    apmu_ibex_wb_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_wb_i(en_wb_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .result_ex_i(result_ex_i),
        .instr_is_load_i(instr_is_load_i), .rf_we_id_i(rf_we_id_i),
        .rf_waddr_id_i(rf_waddr_id_i), .pc_id_i(pc_id_i),
        .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_rdata_i(lsu_rdata_i),
        .lsu_resp_err_i(lsu_resp_err_i), .ready_wb_o(ready_wb_o),
        .rf_we_wb_o(rf_we_wb_o), .rf_waddr_wb_o(rf_waddr_wb_o),
        .rf_wdata_wb_o(rf_wdata_wb_o), .rf_wdata_fwd_valid_o(rf_wdata_fwd_valid_o),
        .instr_done_wb_o(instr_done_wb_o), .pc_wb_o(pc_wb_o),
        .load_err_o(load_err_o), .spurious_resp_o(spurious_resp_o),
        .retired_cnt_o(retired_cnt_o)
    );

    apmu_ibex_wb_stage #(.CntWidth(4), .ResetAll(1'b1)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_wb_i(en_wb_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .result_ex_i(result_ex_i),
        .instr_is_load_i(instr_is_load_i), .rf_we_id_i(rf_we_id_i),
        .rf_waddr_id_i(rf_waddr_id_i), .pc_id_i(pc_id_i),
        .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_rdata_i(lsu_rdata_i),
        .lsu_resp_err_i(lsu_resp_err_i), .ready_wb_o(d4_ready),
        .rf_we_wb_o(d4_we), .rf_waddr_wb_o(d4_waddr),
        .rf_wdata_wb_o(d4_wdata), .rf_wdata_fwd_valid_o(d4_fwd),
        .instr_done_wb_o(d4_done), .pc_wb_o(d4_pc),
        .load_err_o(d4_lerr), .spurious_resp_o(d4_spur),
        .retired_cnt_o(d4_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one WB slot plus the architectural side effects.
    bit          m_busy, m_load, m_we, m_spur;
    logic [4:0]  m_rd;
    logic [31:0] m_pc, m_res;
    int unsigned m_cnt;

    task automatic model_reset();
        m_busy = 0; m_load = 0; m_we = 0; m_spur = 0; m_cnt = 0;
    endtask

    // Drive one cycle of inputs, check all outputs against the model at the
    // falling edge, then advance the model across the rising edge.
    task automatic step(input bit en, input bit fl, input bit exv, input bit ld,
                        input bit we, input logic [4:0] rd, input logic [31:0] res,
                        input logic [31:0] pc, input bit rv, input logic [31:0] rdata,
                        input bit err);
        bit resp, done, wexp, rdy, acc;
        en_wb_i = en; flush_i = fl; ex_valid_i = exv; instr_is_load_i = ld;
        rf_we_id_i = we; rf_waddr_id_i = rd; result_ex_i = res; pc_id_i = pc;
        lsu_resp_valid_i = rv; lsu_rdata_i = rdata; lsu_resp_err_i = err;
        @(negedge clk_i);
        resp = m_busy && m_load && rv;
        done = (m_busy && !m_load) || resp;
        wexp = (m_busy && !m_load && m_we) || (resp && m_we && !err);
        rdy  = !(m_busy && m_load) || rv;
        acc  = en && exv && rdy && !fl;
        chk("ready", ready_wb_o, rdy);
        chk("done", instr_done_wb_o, done);
        chk("rf_we", rf_we_wb_o, wexp);
        chk("load_err", load_err_o, resp && err);
        chk("spurious", spurious_resp_o, m_spur);
        chk("cnt", retired_cnt_o, m_cnt);
        chk("cnt4", d4_cnt, m_cnt % 16);
        chk("done4", d4_done, done);
        if (m_busy) begin
            chk("waddr", rf_waddr_wb_o, m_rd);
            chk("pc", pc_wb_o, m_pc);
            if (m_load) chk("wdata_ld", rf_wdata_wb_o, rdata);
            else        chk("wdata_alu", rf_wdata_wb_o, m_res);
            if (!m_load)    chk("fwd_alu", rf_wdata_fwd_valid_o, m_we);
            else if (!rv)   chk("fwd_wait", rf_wdata_fwd_valid_o, 1'b0);
        end else begin
            chk("fwd_idle", rf_wdata_fwd_valid_o, 1'b0);
        end
        // Model update for the coming rising edge.
        if (rv && !(m_busy && m_load)) m_spur = 1;
        m_cnt += done;
        if (acc) begin
            m_busy = 1; m_load = ld; m_we = we && (rd != 0);
            m_rd = rd; m_pc = pc; m_res = res;
        end else if (!(m_busy && m_load && !rv)) begin
            m_busy = 0;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic idle(input bit rv);
        step(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, rv, 32'h0, 0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] res);
        step(1, 0, 1, 0, 1, rd, res, 32'h100 + {27'h0, rd}, 0, 32'h0, 0);
    endtask

    task automatic do_reset();
        rst_ni = 0;
        en_wb_i = 0; flush_i = 0; ex_valid_i = 0; instr_is_load_i = 0;
        rf_we_id_i = 0; rf_waddr_id_i = 0; result_ex_i = 0; pc_id_i = 0;
        lsu_resp_valid_i = 0; lsu_rdata_i = 0; lsu_resp_err_i = 0;
        #1;
        model_reset();
        chk("rst_ready", ready_wb_o, 1'b1);
        chk("rst_we", rf_we_wb_o, 1'b0);
        chk("rst_done", instr_done_wb_o, 1'b0);
        chk("rst_waddr", rf_waddr_wb_o, 5'd0);
        chk("rst_pc", pc_wb_o, 32'h0);
        chk("rst_cnt", retired_cnt_o, 32'h0);
        chk("rst_spur", spurious_resp_o, 1'b0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i); #1;
    endtask

    initial begin
        rst_ni = 1;
        #2;
        do_reset();

        // 1: ALU result retires one cycle after accept.
        alu(5'd5, 32'hDEADBEEF);
        idle(0);
        // 2: load with response three cycles later.
        step(1, 0, 1, 1, 1, 5'd7, 32'h0, 32'h200, 0, 32'h0, 0);
        idle(0); idle(0);
        step(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 32'h12345678, 0);
        // 3: load returning a bus error.
        step(1, 0, 1, 1, 1, 5'd9, 32'h0, 32'h204, 0, 32'h0, 0);
        step(1, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1, 32'hCAFE0000, 1);
        // 4: write to x0, then a flushed instruction must not be captured.
        alu(5'd0, 32'h55AA55AA);
        step(1, 1, 1, 0, 1, 5'd3, 32'h11111111, 32'h300, 0, 32'h0, 0);
        idle(0);
        // Stalled load: flush while waiting has no effect on it.
        step(1, 0, 1, 1, 1, 5'd4, 32'h0, 32'h304, 0, 32'h0, 0);
        step(1, 1, 1, 0, 1, 5'd6, 32'h1, 32'h308, 0, 32'h0, 0);
        // 5: response and next ALU accept in the same cycle.
        step(1, 0, 1, 0, 1, 5'd8, 32'hA5A5A5A5, 32'h30C, 1, 32'h87654321, 0);
        idle(0);
        idle(1);           // spurious response in WB_IDLE
        idle(0); idle(0);  // flag must stay set
        // 6: enough back-to-back retirements to wrap the 4-bit counter.
        for (int i = 0; i < 18; i++) alu(5'(i + 1), 32'(i * 3));
        idle(0);

        // Reset while a load waits; a later response becomes spurious.
        do_reset();
        step(1, 0, 1, 1, 1, 5'd12, 32'h0, 32'h400, 0, 32'h0, 0);
        idle(0);
        @(negedge clk_i); #1;
        rst_ni = 0;
        en_wb_i = 0; ex_valid_i = 0; lsu_resp_valid_i = 0;
        #1;
        chk("midrst_ready", ready_wb_o, 1'b1);
        chk("midrst_pc", pc_wb_o, 32'h0);
        chk("midrst_waddr", rf_waddr_wb_o, 5'd0);
        chk("midrst_done", instr_done_wb_o, 1'b0);
        model_reset();
        @(posedge clk_i); #1;
        rst_ni = 1;
        idle(1);
        idle(0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit rv;
            rv = (m_busy && m_load) ? ($urandom % 3 == 0) : ($urandom % 40 == 0);
            step($urandom % 8 != 0, $urandom % 10 == 0, $urandom % 4 != 0,
                 $urandom % 5 < 2, $urandom % 4 != 0, 5'($urandom % 8),
                 $urandom, $urandom, rv, $urandom, $urandom % 4 == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
